// File: rtl/pc_hazard_controller_pkg.sv
// Shared state encodings, register-address defaults and control-word constants
// for the fetch/pipeline hazard controller.
package pc_hazard_controller_pkg;

  localparam int unsigned REG_AW_DEF = 5;
  localparam int unsigned X0         = 0;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  // One bit per pipeline control output, MSB first.
  typedef struct packed {
    logic pc_sel;
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_write;
    logic id_ex_flush;
    logic ex_mem_write;
  } ctrl_t;

  localparam ctrl_t CTRL_FREEZE    = ctrl_t'(7'b0000000);
  localparam ctrl_t CTRL_BOOT      = ctrl_t'(7'b0001011);
  localparam ctrl_t CTRL_RUN       = ctrl_t'(7'b0110101);
  localparam ctrl_t CTRL_BRANCH    = ctrl_t'(7'b1101011);
  localparam ctrl_t CTRL_BUBBLE    = ctrl_t'(7'b0000011);
  localparam ctrl_t CTRL_HALT      = ctrl_t'(7'b0000011);
  localparam ctrl_t CTRL_HALT_BUSY = ctrl_t'(7'b0000010);

endpackage

// File: rtl/pc_hazard_controller_load_use_detect.sv
// Combinational load-use hazard detect: a load in EX writes a register the
// instruction in ID reads. Writes to x0 never create a hazard.
module load_use_detect
  import pc_hazard_controller_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] i_id_rs1,
  input  logic [REG_AW-1:0] i_id_rs2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_mem_read,
  output logic              o_load_use
);

  logic w_rd_nonzero;
  logic w_rd_match;

  assign w_rd_nonzero = (i_ex_rd != REG_AW'(X0));
  assign w_rd_match   = (i_ex_rd == i_id_rs1) | (i_ex_rd == i_id_rs2);
  assign o_load_use   = i_ex_mem_read & w_rd_nonzero & w_rd_match;

endmodule

// File: rtl/pc_hazard_controller.sv
// PC sequencing and pipeline-register enable/flush control for the 5-stage core.
// Optional performance counters are built when PC_HAZ_PERF_CNT_EN is defined.
module pc_hazard_controller
  import pc_hazard_controller_pkg::*;
#(
  parameter int unsigned MAX_STALL = 256,
  parameter int unsigned REG_AW    = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              branch_taken_ex,
  input  logic              mem_busy,
  input  logic              halt_req,
  output logic              pc_sel,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_write,
  output logic              id_ex_flush,
  output logic              ex_mem_write,
  output logic              halted,
  output logic              timeout_err
`ifdef PC_HAZ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cyc,
  output logic [31:0]       perf_flush_cnt,
  output logic [31:0]       perf_lu_cnt
`endif
);

  localparam int unsigned         CNT_W     = $clog2(MAX_STALL + 1);
  localparam logic [CNT_W-1:0]    STALL_MAX = CNT_W'(MAX_STALL);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_timeout_err;
  ctrl_t            w_ctrl;
  logic             w_load_use;
  logic             w_run;
  logic             w_run_busy;
  logic             w_run_branch;
  logic             w_run_lu;
  logic             w_run_halt;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_ex_rd       (ex_rd),
    .i_ex_mem_read (ex_mem_read),
    .o_load_use    (w_load_use)
  );

  // RUN-state priority decode: busy > branch > load-use > halt.
  assign w_run        = (r_state == ST_RUN);
  assign w_run_busy   = w_run & mem_busy;
  assign w_run_branch = w_run & ~mem_busy & branch_taken_ex;
  assign w_run_lu     = w_run & ~mem_busy & ~branch_taken_ex & w_load_use;
  assign w_run_halt   = w_run & ~mem_busy & ~branch_taken_ex & ~w_load_use & halt_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BOOT:     w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_run_busy) begin
          w_state_nxt = ST_MEM_WAIT;
        end else if (w_run_halt) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_MEM_WAIT: if (!mem_busy) w_state_nxt = ST_RUN;
      ST_HALT:     w_state_nxt = ST_HALT;
    endcase
  end

  always_comb begin
    w_ctrl = CTRL_FREEZE;
    unique case (r_state)
      ST_BOOT:     w_ctrl = CTRL_BOOT;
      ST_RUN: begin
        if (w_run_busy) begin
          w_ctrl = CTRL_FREEZE;
        end else if (w_run_branch) begin
          w_ctrl = CTRL_BRANCH;
        end else if (w_run_lu || w_run_halt) begin
          w_ctrl = CTRL_BUBBLE;
        end else begin
          w_ctrl = CTRL_RUN;
        end
      end
      ST_MEM_WAIT: w_ctrl = CTRL_FREEZE;
      ST_HALT:     w_ctrl = mem_busy ? CTRL_HALT_BUSY : CTRL_HALT;
    endcase
  end

  assign pc_sel       = w_ctrl.pc_sel & w_ctrl.pc_write;
  assign pc_write     = w_ctrl.pc_write;
  assign if_id_write  = w_ctrl.if_id_write;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_write  = w_ctrl.id_ex_write;
  assign id_ex_flush  = w_ctrl.id_ex_flush;
  assign ex_mem_write = w_ctrl.ex_mem_write;
  assign halted       = (r_state == ST_HALT);
  assign timeout_err  = r_timeout_err;

  // Saturating wait counter; cleared on the cycle memory becomes ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_state != ST_MEM_WAIT || !mem_busy) begin
      r_stall_cnt <= '0;
    end else if (r_stall_cnt != STALL_MAX) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
    end else if (r_state == ST_MEM_WAIT && r_stall_cnt == STALL_MAX) begin
      r_timeout_err <= 1'b1;
    end
  end

`ifdef PC_HAZ_PERF_CNT_EN
  logic [31:0] r_perf_stall_cyc;
  logic [31:0] r_perf_flush_cnt;
  logic [31:0] r_perf_lu_cnt;

  // Stall cycles include the RUN cycle that first sees mem_busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_stall_cyc <= '0;
      r_perf_flush_cnt <= '0;
      r_perf_lu_cnt    <= '0;
    end else begin
      if (w_run_busy || r_state == ST_MEM_WAIT) r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
      if (w_run_branch) r_perf_flush_cnt <= r_perf_flush_cnt + 32'd1;
      if (w_run_lu)     r_perf_lu_cnt    <= r_perf_lu_cnt + 32'd1;
    end
  end

  assign perf_stall_cyc = r_perf_stall_cyc;
  assign perf_flush_cnt = r_perf_flush_cnt;
  assign perf_lu_cnt    = r_perf_lu_cnt;
`endif

endmodule

// File: tb/tb_pc_hazard_controller.sv
// Table-driven bench for pc_hazard_controller with MAX_STALL=4; expected
// control words go through a scoreboard queue and are compared mid-cycle.
module tb_pc_hazard_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic [4:0] ex_rd = '0;
  logic       ex_mem_read = 1'b0;
  logic       branch_taken_ex = 1'b0;
  logic       mem_busy = 1'b0;
  logic       halt_req = 1'b0;
  logic       pc_sel, pc_write, if_id_write, if_id_flush;
  logic       id_ex_write, id_ex_flush, ex_mem_write, halted, timeout_err;
`ifdef PC_HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_lu_cnt;
`endif

  always #5 clk = ~clk;

  pc_hazard_controller #(
    .MAX_STALL (4),
    .REG_AW    (5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .branch_taken_ex (branch_taken_ex),
    .mem_busy        (mem_busy),
    .halt_req        (halt_req),
    .pc_sel          (pc_sel),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_write     (id_ex_write),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_write    (ex_mem_write),
    .halted          (halted),
    .timeout_err     (timeout_err)
`ifdef PC_HAZ_PERF_CNT_EN
    ,
    .perf_stall_cyc  (perf_stall_cyc),
    .perf_flush_cnt  (perf_flush_cnt),
    .perf_lu_cnt     (perf_lu_cnt)
`endif
  );

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       mb;
    logic       hr;
  } stim_t;

  typedef struct {
    string      name;
    stim_t      stim;
    logic [8:0] val;
    logic [8:0] mask;
  } vec_t;

  // Output order: pc_sel pc_write if_id_write if_id_flush id_ex_write id_ex_flush ex_mem_write halted
  localparam logic [7:0] E_BOOT  = 8'b0001_0110;
  localparam logic [7:0] E_RUN   = 8'b0110_1010;
  localparam logic [7:0] E_LU    = 8'b0000_0110;
  localparam logic [7:0] E_BR    = 8'b1101_0110;
  localparam logic [7:0] E_FRZ   = 8'b0000_0000;
  localparam logic [7:0] E_HLT   = 8'b0000_0111;
  localparam logic [7:0] E_HLTB  = 8'b0000_0101;
  localparam logic [7:0] M_ALL   = 8'b1111_1111;
  localparam logic [7:0] M_LU    = 8'b1111_0111;
  localparam logic [7:0] M_BR    = 8'b1101_0111;
  localparam logic [7:0] M_HB    = 8'b1111_0011;

  vec_t tbl[$];
  vec_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;

  function automatic stim_t mkin(int rs1, int rs2, int rd, logic mr, logic br, logic mb, logic hr);
    stim_t s;
    s.rs1 = 5'(rs1);
    s.rs2 = 5'(rs2);
    s.rd  = 5'(rd);
    s.mr  = mr;
    s.br  = br;
    s.mb  = mb;
    s.hr  = hr;
    return s;
  endfunction

  function automatic vec_t mk(string name, stim_t s, logic [7:0] val, logic [7:0] m, logic to, logic tom);
    vec_t v;
    v.name = name;
    v.stim = s;
    v.val  = {val, to};
    v.mask = {m, tom};
    return v;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare at the falling edge.
  task automatic step(input vec_t v, input logic rstv);
    vec_t       e;
    logic [8:0] got;
    @(posedge clk);
    #1;
    rst_n           = rstv;
    id_rs1          = v.stim.rs1;
    id_rs2          = v.stim.rs2;
    ex_rd           = v.stim.rd;
    ex_mem_read     = v.stim.mr;
    branch_taken_ex = v.stim.br;
    mem_busy        = v.stim.mb;
    halt_req        = v.stim.hr;
    sb.push_back(v);
    @(negedge clk);
    e   = sb.pop_front();
    got = {pc_sel, pc_write, if_id_write, if_id_flush, id_ex_write,
           id_ex_flush, ex_mem_write, halted, timeout_err};
    n_checks++;
    if (((got ^ e.val) & e.mask) != 9'd0) begin
      n_err++;
      $display("FAIL %s: got %b required %b (mask %b)", e.name, got, e.val, e.mask);
    end
  endtask

  initial begin
    stim_t idl;
    stim_t hs;
    idl = mkin(1, 2, 3, 1'b0, 1'b0, 1'b0, 1'b0);

    tbl.push_back(mk("boot_cycle0",    idl,                                      E_BOOT, M_ALL, 1'b0, 1'b1));
    tbl.push_back(mk("run_cycle1",     idl,                                      E_RUN,  M_ALL, 1'b0, 1'b1));
    tbl.push_back(mk("lu_rs2",         mkin(1, 5, 5, 1'b1, 1'b0, 1'b0, 1'b0),    E_LU,   M_LU,  1'b0, 1'b1));
    tbl.push_back(mk("after_bubble",   idl,                                      E_RUN,  M_ALL, 1'b0, 1'b1));
    tbl.push_back(mk("lu_rs1",         mkin(7, 2, 7, 1'b1, 1'b0, 1'b0, 1'b0),    E_LU,   M_LU,  1'b0, 1'b1));
    tbl.push_back(mk("lu_rd_x0",       mkin(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0),    E_RUN,  M_ALL, 1'b0, 1'b1));
    tbl.push_back(mk("no_load_match",  mkin(4, 4, 4, 1'b0, 1'b0, 1'b0, 1'b0),    E_RUN,  M_ALL, 1'b0, 1'b1));
    tbl.push_back(mk("br_over_lu",     mkin(6, 2, 6, 1'b1, 1'b1, 1'b0, 1'b0),    E_BR,   M_BR,  1'b0, 1'b1));
    tbl.push_back(mk("br_over_halt",   mkin(1, 2, 3, 1'b0, 1'b1, 1'b0, 1'b1),    E_BR,   M_BR,  1'b0, 1'b1));
    tbl.push_back(mk("not_halted",     idl,                                      E_RUN,  M_ALL, 1'b0, 1'b1));
    tbl.push_back(mk("br_alone",       mkin(1, 2, 3, 1'b0, 1'b1, 1'b0, 1'b0),    E_BR,   M_BR,  1'b0, 1'b1));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk($sformatf("busy3_%0d", i), mkin(1, 2, 3, 1'b0, 1'b1, 1'b1, 1'b0), E_FRZ, M_ALL, 1'b0, 1'b1));
    tbl.push_back(mk("busy3_exit",     mkin(1, 2, 3, 1'b0, 1'b1, 1'b0, 1'b0),    E_FRZ,  M_ALL, 1'b0, 1'b1));
    tbl.push_back(mk("br_after_wait",  mkin(1, 2, 3, 1'b0, 1'b1, 1'b0, 1'b0),    E_BR,   M_BR,  1'b0, 1'b1));
    tbl.push_back(mk("idle_a",         idl,                                      E_RUN,  M_ALL, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk($sformatf("busy4_%0d", i), mkin(9, 2, 9, 1'b1, 1'b0, 1'b1, 1'b0), E_FRZ, M_ALL, 1'b0, 1'b1));
    tbl.push_back(mk("busy4_exit",     idl,                                      E_FRZ,  M_ALL, 1'b0, 1'b1));
    tbl.push_back(mk("run_no_timeout", idl,                                      E_RUN,  M_ALL, 1'b0, 1'b1));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk($sformatf("busy6_%0d", i), mkin(1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0), E_FRZ, M_ALL, 1'b0, (i < 5) ? 1'b1 : 1'b0));
    tbl.push_back(mk("busy6_exit",     idl,                                      E_FRZ,  M_ALL, 1'b1, 1'b1));
    tbl.push_back(mk("timeout_sticky", idl,                                      E_RUN,  M_ALL, 1'b1, 1'b1));
    tbl.push_back(mk("halt_req",       mkin(1, 2, 3, 1'b0, 1'b0, 1'b0, 1'b1),    E_LU,   M_LU,  1'b1, 1'b1));

    // Reset state while rst_n is held low.
    step(mk("reset_hold_0", idl, E_BOOT, M_ALL, 1'b0, 1'b1), 1'b0);
    step(mk("reset_hold_1", idl, E_BOOT, M_ALL, 1'b0, 1'b1), 1'b0);

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // HALT is terminal: PC frozen and older instructions keep draining.
    for (int i = 0; i < 20; i++) begin
      hs = mkin(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'($urandom_range(0, 1)));
      step(mk($sformatf("halt_hold_%0d", i), hs, E_HLT, M_LU, 1'b1, 1'b1), 1'b1);
    end
    step(mk("halt_mem_busy",  mkin(1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0), E_HLTB, M_HB,  1'b1, 1'b1), 1'b1);
    step(mk("halt_after_busy", idl,                                  E_HLT,  M_LU,  1'b1, 1'b1), 1'b1);

    // Asynchronous reset mid-HALT.
    step(mk("rst_mid_halt",   idl, E_BOOT, M_ALL, 1'b0, 1'b1), 1'b0);
    step(mk("rst_release",    idl, E_BOOT, M_ALL, 1'b0, 1'b1), 1'b1);
    step(mk("run_after_rst",  idl, E_RUN,  M_ALL, 1'b0, 1'b1), 1'b1);

    // Asynchronous reset mid-MEM_WAIT.
    step(mk("busy_pre_rst_0", mkin(1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0), E_FRZ, M_ALL, 1'b0, 1'b1), 1'b1);
    step(mk("busy_pre_rst_1", mkin(1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0), E_FRZ, M_ALL, 1'b0, 1'b1), 1'b1);
    step(mk("rst_mid_wait",   mkin(1, 2, 3, 1'b0, 1'b0, 1'b1, 1'b0), E_BOOT, M_ALL, 1'b0, 1'b1), 1'b0);
    step(mk("rst_release_2",  idl, E_BOOT, M_ALL, 1'b0, 1'b1), 1'b1);
    step(mk("run_after_rst_2", idl, E_RUN, M_ALL, 1'b0, 1'b1), 1'b1);
    step(mk("lu_after_rst",   mkin(1, 5, 5, 1'b1, 1'b0, 1'b0, 1'b0), E_LU, M_LU, 1'b0, 1'b1), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
